idli_sqi_fetch_m: RTL and testbench
===================================

IDLI_SQI_FETCH_M -- requirements
Module: idli_sqi_fetch_m

Interface
REQ-001 SHALL have port i_sqi_gck, input, 1 -- core clock; the top level also drives it as the SQI memory SCK.
REQ-002 SHALL have port i_sqi_rst_n, input, 1 -- reset, asynchronous, active-low.
REQ-003 SHALL have port i_sqi_req, input, 1 -- start a fetch; sampled only in IDLE.
REQ-004 SHALL have port i_sqi_addr, input, 4 -- address nibble stream from the PC stage, least-significant nibble first, one nibble per cycle.
REQ-005 SHALL have port i_sqi_stop, input, 1 -- end the current transaction.
REQ-006 SHALL have port i_sqi_sio, input, 4 -- memory SIO[3:0] read data.
REQ-007 SHALL have port o_sqi_sio, output, 4 -- memory SIO[3:0] drive data.
REQ-008 SHALL have port o_sqi_sio_oe, output, 1 -- SIO output enable.
REQ-009 SHALL have port o_sqi_cs_n, output, 1 -- memory chip select, active-low.
REQ-010 SHALL have port o_sqi_data, output, 4 -- fetched instruction nibble.
REQ-011 SHALL have port o_sqi_data_vld, output, 1 -- o_sqi_data is valid this cycle.
REQ-012 SHALL have port o_sqi_busy, output, 1 -- block is not in IDLE.

Function
REQ-013 SHALL implement the states IDLE, CAPT, CMD, ADDR, DUMMY and DATA, with a 2-bit cycle counter.
REQ-014 IDLE: when i_sqi_req=1 in cycle 0, SHALL capture i_sqi_addr as address bits [3:0] and go to CAPT.
REQ-015 CAPT: SHALL capture address bits [7:4], [11:8] and [15:12] in cycles 1, 2 and 3, then go to CMD.
REQ-016 CMD: in cycles 4-5, SHALL drive cs_n=0 and oe=1, with o_sqi_sio=0x0 in cycle 4 and 0x3 in cycle 5 (READ 0x03, high nibble first).
REQ-017 ADDR: in cycles 6-9, SHALL drive address bits [15:12], [11:8], [7:4] and [3:0] in that order (most-significant nibble first), with oe=1.
REQ-018 DUMMY: in cycles 10-11, SHALL hold cs_n=0 and oe=0 (turnaround).
REQ-019 DATA: from cycle 12, SHALL register i_sqi_sio every cycle into o_sqi_data with o_sqi_data_vld=1 one cycle later, so the first valid nibble appears in cycle 13.
REQ-020 DATA SHALL continue indefinitely (sequential read, address auto-increments in memory) until stop.
REQ-021 When i_sqi_stop=1 in cycle n in any non-IDLE state, SHALL in cycle n+1 set cs_n=1, oe=0, o_sqi_data_vld=0 and state IDLE.
REQ-022 i_sqi_stop=1 and i_sqi_req=1 together in IDLE: stop SHALL win and no fetch starts.
REQ-023 i_sqi_req while busy SHALL be ignored.
REQ-024 A new req is accepted in the first IDLE cycle after a stop.
REQ-025 Whenever oe=0, o_sqi_sio SHALL be 0x0.
REQ-026 o_sqi_busy SHALL be 1 in every state except IDLE.
REQ-027 Outside DUMMY and DATA, o_sqi_data SHALL hold its last value with vld=0.

Reset
REQ-028 On i_sqi_rst_n=0, asynchronously: state=IDLE, counter=0, address buffer=0, cs_n=1, oe=0, o_sqi_sio=0x0, o_sqi_data=0x0, vld=0, busy=0.
REQ-029 Reset mid-transaction SHALL abort immediately (cs_n=1) with no further data output.

Configuration
REQ-030 Macro IDLI_SQI_NIBBLE_SWAP_EN SHALL be the only compile-time option.
REQ-031 Without IDLI_SQI_NIBBLE_SWAP_EN: data SHALL be output in arrival order (high nibble of each byte first), first vld in cycle 13.
REQ-032 With IDLI_SQI_NIBBLE_SWAP_EN: the block SHALL buffer each byte and output its low nibble then its high nibble, so the byte received in cycles 12-13 is output in cycles 14-15.
REQ-033 With IDLI_SQI_NIBBLE_SWAP_EN: vld SHALL be 1 on both nibbles of each complete byte.
REQ-034 With IDLI_SQI_NIBBLE_SWAP_EN: stop SHALL discard any partially received or buffered byte.

Verification
REQ-035 Reset, then req with address nibbles 0x4,0x3,0x2,0x1 -> o_sqi_sio sequence 0,3,1,2,3,4 in cycles 4-9; cs_n falls in cycle 4; oe=0 in cycles 10-11.
REQ-036 Memory returns 0xA,0xB,0xC,0xD from cycle 12 -> without the macro, data A,B,C,D with vld in cycles 13-16; with the macro, B,A,D,C in cycles 14-17.
REQ-037 Stop in cycle 7 (during ADDR) -> cs_n=1 and busy=0 in cycle 8; vld never asserted.
REQ-038 req and stop both high in IDLE -> busy stays 0 and cs_n stays 1.
REQ-039 req pulsed in cycle 5 of an active fetch -> no effect on the sequence.
REQ-040 Reset asserted in cycle 14 -> all outputs at reset values immediately; a req after release starts a fresh sequence at cycle 0.

Source files
------------

// File: rtl/idli_sqi_fetch_m.sv
// SQI instruction fetch: captures a 16-bit address nibble-serially, issues READ 0x03 and streams data nibbles.
// Optional IDLI_SQI_NIBBLE_SWAP_EN: emit each received byte low nibble first.
module idli_sqi_fetch_m (
  input  logic       i_sqi_gck,
  input  logic       i_sqi_rst_n,
  input  logic       i_sqi_req,
  input  logic [3:0] i_sqi_addr,
  input  logic       i_sqi_stop,
  input  logic [3:0] i_sqi_sio,
  output logic [3:0] o_sqi_sio,
  output logic       o_sqi_sio_oe,
  output logic       o_sqi_cs_n,
  output logic [3:0] o_sqi_data,
  output logic       o_sqi_data_vld,
  output logic       o_sqi_busy
);

  typedef enum logic [2:0] {IDLE, CAPT, CMD, ADDR, DUMMY, DATA} st_t;

  st_t         st_q, st_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [15:0] addr_q;
  logic [3:0]  data_q;
  logic        vld_q;
  logic        run;

  assign run = (st_q == DATA) && !i_sqi_stop;

  always_ff @(posedge i_sqi_gck or negedge i_sqi_rst_n) begin
    if (!i_sqi_rst_n) begin
      st_q  <= IDLE;
      cnt_q <= '0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q + 2'd1;
    case (st_q)
      IDLE: begin
        cnt_d = '0;
        if (i_sqi_req && !i_sqi_stop) st_d = CAPT;
      end
      CAPT:  if (cnt_q == 2'd2) begin st_d = CMD;   cnt_d = '0; end
      CMD:   if (cnt_q == 2'd1) begin st_d = ADDR;  cnt_d = '0; end
      ADDR:  if (cnt_q == 2'd3) begin st_d = DUMMY; cnt_d = '0; end
      DUMMY: if (cnt_q == 2'd1) begin st_d = DATA;  cnt_d = '0; end
      DATA:  cnt_d = '0;
      default: begin st_d = IDLE; cnt_d = '0; end
    endcase
    // stop beats everything, including a req seen in IDLE
    if (i_sqi_stop && st_q != IDLE) begin
      st_d  = IDLE;
      cnt_d = '0;
    end
  end

  always_comb begin
    o_sqi_cs_n   = (st_q == IDLE) || (st_q == CAPT);
    o_sqi_sio_oe = (st_q == CMD) || (st_q == ADDR);
    o_sqi_busy   = (st_q != IDLE);
    o_sqi_sio    = 4'h0;
    if (st_q == CMD)
      o_sqi_sio = {2'b00, cnt_q[0], cnt_q[0]};
    else if (st_q == ADDR)
      case (cnt_q)
        2'd0:    o_sqi_sio = addr_q[15:12];
        2'd1:    o_sqi_sio = addr_q[11:8];
        2'd2:    o_sqi_sio = addr_q[7:4];
        default: o_sqi_sio = addr_q[3:0];
      endcase
  end

  always_ff @(posedge i_sqi_gck or negedge i_sqi_rst_n) begin
    if (!i_sqi_rst_n)
      addr_q <= '0;
    else if (st_q == IDLE && i_sqi_req && !i_sqi_stop)
      addr_q[3:0] <= i_sqi_addr;
    else if (st_q == CAPT)
      case (cnt_q)
        2'd0:    addr_q[7:4]   <= i_sqi_addr;
        2'd1:    addr_q[11:8]  <= i_sqi_addr;
        default: addr_q[15:12] <= i_sqi_addr;
      endcase
  end

`ifdef IDLI_SQI_NIBBLE_SWAP_EN
  logic [3:0] hi_q;
  logic       ph_q;
  logic       byte_rdy_q;

  // ph_q=0 expects a high nibble; the buffered high nibble is emitted on that same edge
  always_ff @(posedge i_sqi_gck or negedge i_sqi_rst_n) begin
    if (!i_sqi_rst_n) begin
      data_q     <= '0;
      vld_q      <= 1'b0;
      hi_q       <= '0;
      ph_q       <= 1'b0;
      byte_rdy_q <= 1'b0;
    end else if (run) begin
      ph_q <= ~ph_q;
      if (!ph_q) begin
        hi_q  <= i_sqi_sio;
        vld_q <= byte_rdy_q;
        if (byte_rdy_q) data_q <= hi_q;
      end else begin
        data_q     <= i_sqi_sio;
        vld_q      <= 1'b1;
        byte_rdy_q <= 1'b1;
      end
    end else begin
      vld_q      <= 1'b0;
      ph_q       <= 1'b0;
      byte_rdy_q <= 1'b0;
    end
  end
`else
  always_ff @(posedge i_sqi_gck or negedge i_sqi_rst_n) begin
    if (!i_sqi_rst_n) begin
      data_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      vld_q <= run;
      if (run) data_q <= i_sqi_sio;
    end
  end
`endif

  assign o_sqi_data     = data_q;
  assign o_sqi_data_vld = vld_q;

endmodule

// File: tb/tb_idli_sqi_fetch_m.sv
// Directed bench for idli_sqi_fetch_m; cycle 0 is the IDLE cycle where req is presented.
module tb_idli_sqi_fetch_m;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req = 1'b0;
  logic [3:0] addr = '0;
  logic       stop = 1'b0;
  logic [3:0] sio_in = '0;
  logic [3:0] sio_out, data;
  logic       oe, cs_n, vld, busy;

  int cmp_cnt = 0;
  int err_cnt = 0;

  logic [3:0] sio_tab [6] = '{4'h0, 4'h3, 4'h1, 4'h2, 4'h3, 4'h4};
  logic [3:0] mem_tab [7] = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF, 4'h0};
`ifdef IDLI_SQI_NIBBLE_SWAP_EN
  localparam int FIRST_VLD = 14;
  logic [3:0] dat_tab [5] = '{4'hB, 4'hA, 4'hD, 4'hC, 4'hF};
`else
  localparam int FIRST_VLD = 13;
  logic [3:0] dat_tab [6] = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF};
`endif

  idli_sqi_fetch_m dut (
    .i_sqi_gck      (clk),
    .i_sqi_rst_n    (rst_n),
    .i_sqi_req      (req),
    .i_sqi_addr     (addr),
    .i_sqi_stop     (stop),
    .i_sqi_sio      (sio_in),
    .o_sqi_sio      (sio_out),
    .o_sqi_sio_oe   (oe),
    .o_sqi_cs_n     (cs_n),
    .o_sqi_data     (data),
    .o_sqi_data_vld (vld),
    .o_sqi_busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    cmp_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".cs_n"}, 16'(cs_n), 16'd1);
    chk({tag, ".busy"}, 16'(busy), 16'd0);
    chk({tag, ".oe"},   16'(oe),   16'd0);
    chk({tag, ".sio"},  16'(sio_out), 16'h0);
    chk({tag, ".vld"},  16'(vld),  16'd0);
  endtask

  // Entered just after a posedge; drives cycles 0..last, req also pulsed in cycle 5.
  task automatic run_seq(input string tag, input int last, input int stop_at, input int hold_d);
    for (int c = 0; c <= last; c++) begin
      req    = (c == 0) || (c == 5);
      addr   = (c < 4) ? 4'(4 - c) : 4'h0;
      stop   = (c == stop_at);
      sio_in = (c >= 12 && c <= 18) ? mem_tab[c - 12] : 4'h0;
      @(negedge clk);
      if (stop_at >= 0 && c > stop_at) begin
        chk_idle($sformatf("%s.c%0d.post_stop", tag, c));
      end else begin
        chk($sformatf("%s.c%0d.cs_n", tag, c), 16'(cs_n), (c >= 4) ? 16'd0 : 16'd1);
        chk($sformatf("%s.c%0d.busy", tag, c), 16'(busy), (c >= 1) ? 16'd1 : 16'd0);
        chk($sformatf("%s.c%0d.oe",   tag, c), 16'(oe), (c >= 4 && c <= 9) ? 16'd1 : 16'd0);
        chk($sformatf("%s.c%0d.sio",  tag, c), 16'(sio_out),
            (c >= 4 && c <= 9) ? 16'(sio_tab[c - 4]) : 16'h0);
        chk($sformatf("%s.c%0d.vld",  tag, c), 16'(vld), (c >= FIRST_VLD) ? 16'd1 : 16'd0);
        if (c >= FIRST_VLD && c <= 18)
          chk($sformatf("%s.c%0d.data", tag, c), 16'(data), 16'(dat_tab[c - FIRST_VLD]));
      end
      if (c == 0 && hold_d >= 0)
        chk($sformatf("%s.data_hold", tag), 16'(data), 16'(hold_d));
      @(posedge clk); #1;
    end
    req = 1'b0; stop = 1'b0; addr = '0; sio_in = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    #2;
    chk("rst.cs_n", 16'(cs_n), 16'd1);
    chk("rst.busy", 16'(busy), 16'd0);
    chk("rst.data", 16'(data), 16'h0);
    chk("rst.vld",  16'(vld),  16'd0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // full fetch at 0x1234, stopped in cycle 18
    run_seq("main", 18, 18, -1);
    // next fetch starts in first IDLE cycle after the stop; stopped during ADDR
    run_seq("stop_addr", 10, 7, 15);

    // req and stop together in IDLE
    req = 1'b1; stop = 1'b1; addr = 4'h9;
    @(negedge clk);
    chk("reqstop.c0.busy", 16'(busy), 16'd0);
    @(posedge clk); #1;
    req = 1'b0; stop = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_idle($sformatf("reqstop.c%0d", i + 1));
      @(posedge clk); #1;
    end

    // asynchronous reset in cycle 14, then a fresh fetch
    run_seq("pre_rst", 13, -1, -1);
    #1 rst_n = 1'b0;
    #1;
    chk_idle("async_rst");
    chk("async_rst.data", 16'(data), 16'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_idle("in_rst");
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_seq("post_rst", 17, -1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end
endmodule
